// File: rtl/sound_event_queue.sv
// Purpose: queues eat/over/start game events and issues them as evt/trig pairs to sound_controller.
// Latency: event pulse sampled at edge n with the queue empty and issuer idle -> trig high in the cycle after edge n+1.
// Backpressure: none upstream; START/EAT into a full queue are discarded and counted, OVER flushes and always lands.
//
// Ports:
//   clk, rst_n                 system clock, asynchronous active-low reset
//   ev_eat, ev_over, ev_start  single-cycle event pulses from the game FSM
//   mute                       level; 1 flushes the queue, ignores pulses and blocks new issues
//   evt                        last issued event code (01 EAT, 10 OVER, 11 START; 00 only after reset)
//   trig                       single-cycle issue strobe
//   busy                       high while the post-issue hold-off runs
//   q_level                    number of queued events
//   drop_cnt                   saturating count of discarded events
module sound_event_queue #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned GAP_CYCLES = CLK_FREQ / 1000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ev_eat,
  input  logic                         ev_over,
  input  logic                         ev_start,
  input  logic                         mute,
  output logic [1:0]                   evt,
  output logic                         trig,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   q_level,
  output logic [7:0]                   drop_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);

  localparam logic [1:0] EV_NONE  = 2'b00;
  localparam logic [1:0] EV_EAT   = 2'b01;
  localparam logic [1:0] EV_OVER  = 2'b10;
  localparam logic [1:0] EV_START = 2'b11;

  // Hold-off reload values. The issue edge, the cycle spent seeing the counter
  // at zero and the IDLE cycle before the next pop add two cycles on top of the
  // count, so subtracting 2 makes back-to-back issues exactly D + GAP apart.
  localparam logic [31:0] HOLD_EAT   = 32'(CLK_FREQ / 20 + GAP_CYCLES - 2);
  localparam logic [31:0] HOLD_OVER  = 32'(CLK_FREQ / 2  + GAP_CYCLES - 2);
  localparam logic [31:0] HOLD_START = 32'(CLK_FREQ / 10 + GAP_CYCLES - 2);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   hold_q, hold_d;
  logic [1:0]    evt_q, evt_d;
  logic          trig_q, trig_d;

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [LW-1:0] level;
  logic [7:0]    drop_q;

  logic          empty, full, pop;
  logic          push, flush_over;
  logic [1:0]    push_code;
  logic [1:0]    n_drop;
  logic [1:0]    head;
  logic [8:0]    drop_sum;

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));
  assign head  = mem[rd_ptr];
  assign pop   = (state_q == IDLE) && !empty && !mute;

  // Enqueue decode: one write per cycle, OVER > START > EAT. A pop in the
  // same cycle frees the slot a write into a full queue needs.
  always_comb begin
    push       = 1'b0;
    push_code  = EV_NONE;
    flush_over = 1'b0;
    n_drop     = 2'd0;
    if (!mute) begin
      if (ev_over) begin
        flush_over = 1'b1;
        n_drop     = {1'b0, ev_start} + {1'b0, ev_eat};
      end else if (ev_start) begin
        n_drop = {1'b0, ev_eat};
        if (!full || pop) begin
          push      = 1'b1;
          push_code = EV_START;
        end else begin
          n_drop = n_drop + 2'd1;
        end
      end else if (ev_eat) begin
        if (!full || pop) begin
          push      = 1'b1;
          push_code = EV_EAT;
        end else begin
          n_drop = 2'd1;
        end
      end
    end
  end

  // Storage has no reset; only the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (!mute) begin
      if (flush_over) begin
        mem[0] <= EV_OVER;
      end else if (push) begin
        mem[wr_ptr] <= push_code;
      end
    end
  end

  // A pop coinciding with an OVER flush still issues the old head: it has
  // already left the queue, and OVER becomes the sole remaining entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (mute) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (flush_over) begin
      rd_ptr <= '0;
      wr_ptr <= AW'(1);
      level  <= LW'(1);
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign drop_sum = {1'b0, drop_q} + {7'd0, n_drop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= 8'd0;
    end else if (drop_sum > 9'd255) begin
      drop_q <= 8'd255;
    end else begin
      drop_q <= drop_sum[7:0];
    end
  end

  // Issue FSM: IDLE pops and strobes; WAIT counts the hold-off down to zero.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    evt_d   = evt_q;
    trig_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = WAIT;
          trig_d  = 1'b1;
          evt_d   = head;
          case (head)
            EV_OVER:  hold_d = HOLD_OVER;
            EV_START: hold_d = HOLD_START;
            default:  hold_d = HOLD_EAT;
          endcase
        end
      end
      WAIT: begin
        if (hold_q == 32'd0) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q - 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= 32'd0;
      evt_q   <= EV_NONE;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      evt_q   <= evt_d;
      trig_q  <= trig_d;
    end
  end

  assign evt      = evt_q;
  assign trig     = trig_q;
  assign busy     = (state_q == WAIT);
  assign q_level  = level;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_sound_event_queue.sv
module tb_sound_event_queue;

  logic       clk;
  logic       rst_n;
  logic       ev_eat, ev_over, ev_start, mute;
  logic [1:0] evt;
  logic       trig, busy;
  logic [2:0] q_level;
  logic [7:0] drop_cnt;

  int checks;
  int failures;
  int cyc;
  int tn;
  int tcyc [16];
  logic [1:0] tevt [16];

  sound_event_queue #(
    .CLK_FREQ  (1000),
    .DEPTH     (4),
    .GAP_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ev_eat   (ev_eat),
    .ev_over  (ev_over),
    .ev_start (ev_start),
    .mute     (mute),
    .evt      (evt),
    .trig     (trig),
    .busy     (busy),
    .q_level  (q_level),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; sample 1 time unit after the edge and log any trig.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (trig === 1'b1) begin
      if (tn < 16) begin
        tcyc[tn] = cyc;
        tevt[tn] = evt;
      end
      tn++;
    end
  endtask

  task automatic do_reset();
    ev_eat = 1'b0; ev_over = 1'b0; ev_start = 1'b0; mute = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    ev_eat = 1'b0; ev_over = 1'b0; ev_start = 1'b0; mute = 1'b0;
    rst_n = 1'b0;
    #3;
    checks++;
    if ({evt, trig, busy, q_level, drop_cnt} !== 15'd0) begin
      failures++;
      $display("FAIL reset_state got evt=%b trig=%b busy=%b q=%0d drop=%0d exp all 0",
               evt, trig, busy, q_level, drop_cnt);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // START from idle: trig two edges after it is driven, busy on the following cycle.
  task automatic test_latency();
    do_reset();
    repeat (7) tick();
    ev_start = 1'b1;
    tick();
    ev_start = 1'b0;
    checks++;
    if (q_level !== 3'd1 || trig !== 1'b0) begin
      failures++;
      $display("FAIL lat_queued got q=%0d trig=%b exp q=1 trig=0", q_level, trig);
    end
    tick();
    checks++;
    if (trig !== 1'b1 || evt !== 2'b11) begin
      failures++;
      $display("FAIL lat_trig got trig=%b evt=%b exp trig=1 evt=11", trig, evt);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || trig !== 1'b0) begin
      failures++;
      $display("FAIL lat_busy got busy=%b trig=%b exp busy=1 trig=0", busy, trig);
    end
  endtask

  // Three EATs back to back: issues 54 cycles apart (D_EAT 50 + GAP 4).
  task automatic test_back_to_back();
    int n0;
    do_reset();
    n0 = tn;
    ev_eat = 1'b1;
    repeat (3) tick();
    ev_eat = 1'b0;
    repeat (200) tick();
    checks++;
    if (tn - n0 !== 3) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=3", tn - n0);
    end else begin
      checks++;
      if (tcyc[n0+1] - tcyc[n0] !== 54 || tcyc[n0+2] - tcyc[n0+1] !== 54) begin
        failures++;
        $display("FAIL b2b_spacing got=%0d,%0d exp=54,54",
                 tcyc[n0+1] - tcyc[n0], tcyc[n0+2] - tcyc[n0+1]);
      end
      checks++;
      if (tevt[n0] !== 2'b01 || tevt[n0+1] !== 2'b01 || tevt[n0+2] !== 2'b01) begin
        failures++;
        $display("FAIL b2b_evt got=%b,%b,%b exp=01,01,01", tevt[n0], tevt[n0+1], tevt[n0+2]);
      end
    end
    checks++;
    if (q_level !== 3'd0 || evt !== 2'b01) begin
      failures++;
      $display("FAIL b2b_end got q=%0d evt=%b exp q=0 evt=01", q_level, evt);
    end
  endtask

  // Overflow during WAIT, then push+pop on a full queue, then a full-queue drop.
  task automatic test_overflow();
    int k;
    do_reset();
    ev_start = 1'b1; tick(); ev_start = 1'b0;
    tick(); tick();
    ev_eat = 1'b1;
    repeat (6) tick();
    ev_eat = 1'b0;
    checks++;
    if (q_level !== 3'd4 || drop_cnt !== 8'd2) begin
      failures++;
      $display("FAIL ovf_fill got q=%0d drop=%0d exp q=4 drop=2", q_level, drop_cnt);
    end
    k = 0;
    while (busy === 1'b1 && k < 200) begin tick(); k++; end
    checks++;
    if (k >= 200) begin
      failures++;
      $display("FAIL ovf_wait_idle got busy=%b exp 0 within 200 cycles", busy);
    end
    ev_eat = 1'b1;
    tick();
    ev_eat = 1'b0;
    checks++;
    if (trig !== 1'b1 || evt !== 2'b01 || q_level !== 3'd4 || drop_cnt !== 8'd2) begin
      failures++;
      $display("FAIL ovf_pushpop got trig=%b evt=%b q=%0d drop=%0d exp 1 01 4 2",
               trig, evt, q_level, drop_cnt);
    end
    ev_eat = 1'b1;
    tick();
    ev_eat = 1'b0;
    checks++;
    if (q_level !== 3'd4 || drop_cnt !== 8'd3) begin
      failures++;
      $display("FAIL ovf_full_drop got q=%0d drop=%0d exp q=4 drop=3", q_level, drop_cnt);
    end
  endtask

  // OVER flushes queued EATs; nothing but OVER is issued afterwards.
  task automatic test_over_flush();
    int n0, k;
    do_reset();
    ev_start = 1'b1; tick(); ev_start = 1'b0;
    tick(); tick();
    ev_eat = 1'b1;
    repeat (3) tick();
    ev_eat = 1'b0;
    checks++;
    if (q_level !== 3'd3) begin
      failures++;
      $display("FAIL over_pre got q=%0d exp 3", q_level);
    end
    ev_over = 1'b1; tick(); ev_over = 1'b0;
    checks++;
    if (q_level !== 3'd1 || drop_cnt !== 8'd0) begin
      failures++;
      $display("FAIL over_flush got q=%0d drop=%0d exp q=1 drop=0", q_level, drop_cnt);
    end
    n0 = tn;
    k = 0;
    while (tn == n0 && k < 200) begin tick(); k++; end
    checks++;
    if (tn == n0 || evt !== 2'b10) begin
      failures++;
      $display("FAIL over_issue got trigs=%0d evt=%b exp 1 trig with evt=10", tn - n0, evt);
    end
    repeat (520) tick();
    checks++;
    if (tn - n0 !== 1 || q_level !== 3'd0) begin
      failures++;
      $display("FAIL over_no_eat got trigs=%0d q=%0d exp trigs=1 q=0", tn - n0, q_level);
    end
  endtask

  // Simultaneous pulses: only OVER queued, two drops; then drive drop_cnt to saturation.
  task automatic test_priority();
    do_reset();
    ev_eat = 1'b1; ev_start = 1'b1; ev_over = 1'b1;
    tick();
    ev_eat = 1'b0; ev_start = 1'b0; ev_over = 1'b0;
    checks++;
    if (q_level !== 3'd1 || drop_cnt !== 8'd2) begin
      failures++;
      $display("FAIL prio_queue got q=%0d drop=%0d exp q=1 drop=2", q_level, drop_cnt);
    end
    tick();
    checks++;
    if (trig !== 1'b1 || evt !== 2'b10) begin
      failures++;
      $display("FAIL prio_issue got trig=%b evt=%b exp trig=1 evt=10", trig, evt);
    end
    ev_eat = 1'b1; ev_start = 1'b1; ev_over = 1'b1;
    repeat (130) tick();
    ev_eat = 1'b0; ev_start = 1'b0; ev_over = 1'b0;
    checks++;
    if (drop_cnt !== 8'd255) begin
      failures++;
      $display("FAIL prio_saturate got drop=%0d exp 255", drop_cnt);
    end
  endtask

  // Mute mid-WAIT, resume after unmute, then asynchronous reset mid-WAIT.
  task automatic test_mute_reset();
    int n0, k;
    do_reset();
    ev_start = 1'b1; tick(); ev_start = 1'b0;
    tick(); tick();
    ev_eat = 1'b1; repeat (2) tick(); ev_eat = 1'b0;
    checks++;
    if (q_level !== 3'd2 || busy !== 1'b1) begin
      failures++;
      $display("FAIL mute_pre got q=%0d busy=%b exp q=2 busy=1", q_level, busy);
    end
    n0 = tn;
    mute = 1'b1;
    tick();
    checks++;
    if (q_level !== 3'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL mute_flush got q=%0d busy=%b exp q=0 busy=1", q_level, busy);
    end
    ev_eat = 1'b1; ev_over = 1'b1; ev_start = 1'b1;
    tick();
    ev_eat = 1'b0; ev_over = 1'b0; ev_start = 1'b0;
    checks++;
    if (q_level !== 3'd0 || drop_cnt !== 8'd0) begin
      failures++;
      $display("FAIL mute_ignore got q=%0d drop=%0d exp q=0 drop=0", q_level, drop_cnt);
    end
    k = 0;
    while (busy === 1'b1 && k < 200) begin tick(); k++; end
    repeat (5) tick();
    mute = 1'b0;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || tn != n0) begin
      failures++;
      $display("FAIL mute_complete got busy=%b trigs=%0d exp busy=0 trigs=0", busy, tn - n0);
    end
    ev_eat = 1'b1; tick(); ev_eat = 1'b0;
    tick();
    checks++;
    if (trig !== 1'b1 || evt !== 2'b01) begin
      failures++;
      $display("FAIL unmute_issue got trig=%b evt=%b exp trig=1 evt=01", trig, evt);
    end
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || trig !== 1'b0 || evt !== 2'b00 || q_level !== 3'd0) begin
      failures++;
      $display("FAIL rst_midwait got busy=%b trig=%b evt=%b q=%0d exp 0 0 00 0",
               busy, trig, evt, q_level);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    tn       = 0;
    test_reset();
    test_latency();
    test_back_to_back();
    test_overflow();
    test_over_flush();
    test_priority();
    test_mute_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
